// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
// The address fault check is only used when DMEM_ERR_CHECK_EN is defined.
package dmem_pkg;

   localparam int unsigned WORD_W = 32;
   localparam int unsigned BE_W   = 4;
   localparam int unsigned CNT_W  = 4;

   typedef enum logic [1:0] {
      StIdle,
      StWait,
      StResp
   } state_e;

   // Faults on a misaligned byte address or any bit set above the word-index field.
   function automatic logic addr_fault(input logic [WORD_W-1:0] addr,
                                       input int unsigned       addr_width);
      logic [WORD_W-1:0] upper;
      upper = addr >> (addr_width + 2);
      return (addr[1:0] != 2'b00) || (upper != '0);
   endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised storage with per-byte write enables, one synchronous write port and an
// asynchronous read port sharing one address. Contents are not reset.
module dmem_array
   import dmem_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 10
) (
   input  logic                  clk_i,
   input  logic                  we_i,
   input  logic [BE_W-1:0]       be_i,
   input  logic [ADDR_WIDTH-1:0] addr_i,
   input  logic [WORD_W-1:0]     wdata_i,
   output logic [WORD_W-1:0]     rdata_o
);

   localparam int unsigned Depth = 2 ** ADDR_WIDTH;

   logic [WORD_W-1:0] mem_q [Depth];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         for (int i = 0; i < BE_W; i++) begin
            if (be_i[i]) begin
               mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
         end
      end
   end

   assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/dmem_responder.sv
// Target end of the MEM-stage load/store port: valid/ready request, fixed access latency,
// valid/ready response. Define DMEM_ERR_CHECK_EN to flag misaligned/out-of-range accesses.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 10,
   parameter int unsigned LATENCY    = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [3:0]  req_be,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               we_q, we_d;
   logic [WORD_W-1:0]  addr_q, addr_d;
   logic [BE_W-1:0]    be_q, be_d;
   logic [WORD_W-1:0]  wdata_q, wdata_d;
   logic [WORD_W-1:0]  rdata_q, rdata_d;
   logic               err_q, err_d;

   logic               mem_we;
   logic [WORD_W-1:0]  mem_rdata;
   logic               fault;

`ifdef DMEM_ERR_CHECK_EN
   assign fault = addr_fault(addr_q, ADDR_WIDTH);
`else
   // Upper and byte-offset address bits are don't-care; the word index wraps modulo the depth.
   logic unused_addr;
   assign unused_addr = ^{addr_q[WORD_W-1:ADDR_WIDTH+2], addr_q[1:0]};
   assign fault       = 1'b0;
`endif

   dmem_array #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_array (
      .clk_i   (clk),
      .we_i    (mem_we),
      .be_i    (be_q),
      .addr_i  (addr_q[ADDR_WIDTH+1:2]),
      .wdata_i (wdata_q),
      .rdata_o (mem_rdata)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = we_q;
      addr_d  = addr_q;
      be_d    = be_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      mem_we  = 1'b0;

      case (state_q)
         StIdle: begin
            if (req_valid) begin
               we_d    = req_we;
               addr_d  = req_addr;
               be_d    = req_be;
               wdata_d = req_wdata;
               cnt_d   = CNT_W'(LATENCY - 1);
               state_d = StWait;
            end
         end
         StWait: begin
            if (cnt_q == '0) begin
               // Commit edge: the access takes effect here and nowhere else.
               err_d   = fault;
               rdata_d = '0;
               if (!fault) begin
                  if (we_q) begin
                     mem_we = 1'b1;
                  end else begin
                     rdata_d = mem_rdata;
                  end
               end
               state_d = StResp;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         StResp: begin
            if (resp_ready) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         be_q    <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         be_q    <= be_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   assign req_ready  = (state_q == StIdle);
   assign resp_valid = (state_q == StResp);
   assign resp_rdata = rdata_q;
   assign resp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomised bench for dmem_responder: a driver pushes model-predicted responses into a
// queue, an independent monitor pops and compares on each response handshake.
module tb_dmem_responder;

   localparam int unsigned AW    = 10;
   localparam int unsigned LAT   = 2;
   localparam int unsigned DEPTH = 1 << AW;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [31:0] req_addr = '0;
   logic [3:0]  req_be = '0;
   logic [31:0] req_wdata = '0;
   logic        resp_valid;
   logic        resp_ready = 1'b0;
   logic [31:0] resp_rdata;
   logic        resp_err;

   always #5 clk = ~clk;

   dmem_responder #(
      .ADDR_WIDTH (AW),
      .LATENCY    (LAT)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_addr   (req_addr),
      .req_be     (req_be),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err)
   );

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          acc;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] mem_m[int];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          rr_mode = 1;   // 0: always ready, 1: random, 2: held low
   int          last_acc = -1;
   logic [31:0] pool[7] = '{32'h0, 32'h10, 32'h20, 32'h24, 32'h100, 32'h3F8, 32'hFFC};

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      errors++;
      $display("FAIL %s (cycle %0d)", name, cyc);
   endtask

   function automatic bit fault_m(input logic [31:0] a);
`ifdef DMEM_ERR_CHECK_EN
      return (a % 4 != 0) || (a >= 4 * DEPTH);
`else
      return 1'b0;
`endif
   endfunction

   // Reference: the access takes effect at accept time since transactions are strictly serial.
   function automatic exp_t model(input bit we, input logic [31:0] a, input logic [3:0] be,
                                  input logic [31:0] wd, input int acc);
      exp_t        e;
      int          idx;
      logic [31:0] w;
      idx     = int'((a >> 2) % DEPTH);
      e.acc   = acc;
      e.err   = fault_m(a);
      e.rdata = '0;
      if (!e.err) begin
         w = mem_m.exists(idx) ? mem_m[idx] : 32'h0;
         if (we) begin
            for (int i = 0; i < 4; i++) begin
               if (be[i]) w[8*i +: 8] = wd[8*i +: 8];
            end
            mem_m[idx] = w;
         end else begin
            e.rdata = w;
         end
      end
      return e;
   endfunction

   task automatic garbage();
      req_valid = 1'b1;
      req_we    = 1'($urandom_range(0, 1));
      req_addr  = $urandom;
      req_be    = 4'($urandom);
      req_wdata = $urandom;
   endtask

   task automatic issue(input bit we, input logic [31:0] a, input logic [3:0] be,
                        input logic [31:0] wd);
      int n;
      int acc;
      n = 0;
      forever begin
         @(posedge clk);
         #1;
         if (req_ready) break;
         garbage();
         n++;
         if (n > 200) begin
            fail_now("req_accept_timeout");
            req_valid = 1'b0;
            return;
         end
      end
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = a;
      req_be    = be;
      req_wdata = wd;
      @(negedge clk);
      acc = cyc + 1;
      // Accept-to-accept period: L wait cycles, one response cycle, one idle cycle.
      if (rr_mode == 0 && last_acc >= 0) check("accept_spacing", 32'(acc - last_acc), LAT + 2);
      last_acc = acc;
      exp_q.push_back(model(we, a, be, wd, acc));
      @(posedge clk);
      #1;
      garbage();
   endtask

   function automatic logic [31:0] rand_addr();
      logic [31:0] a;
      a = pool[$urandom_range(0, 6)];
      case ($urandom_range(0, 5))
         0: a = a + ($urandom_range(1, 7) << 12);
         1: a = a + 32'($urandom_range(1, 3));
         default: ;
      endcase
      return a;
   endfunction

   task automatic drain();
      int n;
      req_valid = 1'b0;
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(posedge clk);
         n++;
      end
      if (exp_q.size() != 0) begin
         fail_now("drain_timeout");
         exp_q.delete();
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (rr_mode)
            0:       resp_ready = 1'b1;
            2:       resp_ready = 1'b0;
            default: resp_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // Monitor: latency on first valid cycle, stability while stalled, data on handshake.
   initial begin
      bit          held_v;
      logic [31:0] held_rdata;
      logic        held_err;
      exp_t        e;
      held_v = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            held_v = 1'b0;
         end else if (resp_valid) begin
            check("req_ready_in_resp", 32'(req_ready), 32'h0);
            if (!held_v) begin
               if (exp_q.size() == 0) fail_now("unexpected_response");
               else check("latency", 32'(cyc), 32'(exp_q[0].acc + LAT));
            end else begin
               check("hold_rdata", resp_rdata, held_rdata);
               check("hold_err", 32'(resp_err), 32'(held_err));
            end
            held_v     = 1'b1;
            held_rdata = resp_rdata;
            held_err   = resp_err;
            if (resp_ready) begin
               if (exp_q.size() != 0) begin
                  e = exp_q.pop_front();
                  check("resp_rdata", resp_rdata, e.rdata);
                  check("resp_err", 32'(resp_err), 32'(e.err));
               end
               held_v = 1'b0;
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog_timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      repeat (3) @(negedge clk);
      check("reset_req_ready", 32'(req_ready), 32'h1);
      check("reset_resp_valid", 32'(resp_valid), 32'h0);
      check("reset_resp_rdata", resp_rdata, 32'h0);
      check("reset_resp_err", 32'(resp_err), 32'h0);
      rst = 1'b0;

      // Give every pool word a known value.
      for (int i = 0; i < 7; i++) issue(1'b1, pool[i], 4'hF, $urandom);
      drain();

      // Reset in WAIT before the commit edge: the store must be lost.
      n = 0;
      while (!req_ready && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_addr  = 32'h10;
      req_be    = 4'hF;
      req_wdata = 32'hDEADBEEF;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      #2;
      check("midreset_req_ready", 32'(req_ready), 32'h1);
      check("midreset_resp_valid", 32'(resp_valid), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      issue(1'b0, 32'h10, 4'h0, 32'h0);

      // Full store/load, partial lanes, empty lane mask.
      issue(1'b1, 32'h20, 4'hF, 32'h12345678);
      issue(1'b0, 32'h20, 4'h0, 32'h0);
      issue(1'b1, 32'h20, 4'b0101, 32'hAABBCCDD);
      issue(1'b0, 32'h20, 4'h0, 32'h0);
      issue(1'b1, 32'h20, 4'b0000, 32'hFFFFFFFF);
      issue(1'b0, 32'h20, 4'h0, 32'h0);
      drain();

      // Backpressure: response held for several cycles with a request pending.
      rr_mode = 2;
      issue(1'b0, 32'h20, 4'h0, 32'h0);
      repeat (LAT + 6) @(posedge clk);
      #1;
      rr_mode = 1;
      issue(1'b0, 32'h24, 4'h0, 32'h0);

      // Address boundaries and aliasing/fault cases.
      issue(1'b0, 32'hFFC, 4'h0, 32'h0);
      issue(1'b1, 32'h1000, 4'hF, 32'h0BADF00D);
      issue(1'b0, 32'h0, 4'h0, 32'h0);
      issue(1'b0, 32'h1000, 4'h0, 32'h0);
      issue(1'b1, 32'h22, 4'hF, 32'h55555555);
      issue(1'b0, 32'h20, 4'h0, 32'h0);
      drain();

      // Throughput with the response channel always ready.
      rr_mode  = 0;
      last_acc = -1;
      repeat (2) @(posedge clk);
      for (int i = 0; i < 12; i++) issue(1'($urandom_range(0, 1)), rand_addr(), 4'($urandom),
                                         $urandom);
      drain();
      rr_mode  = 1;

      for (int i = 0; i < 150; i++) issue(1'($urandom_range(0, 1)), rand_addr(), 4'($urandom),
                                          $urandom);
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
